cache_data_array_nway: RTL and testbench

Parametrised N-way set-associative cache data store for the memory stage. It replaces the fixed 2-way, 64-set, 8-word, 16-bit array with a configurable geometry. It adds a registered single-cycle read port, byte-enabled writes and an internal block-fill sequencer that loads a whole line from memory one word per beat. Tag/valid and LRU state live outside this block; the cache controller issues way/set/word indices directly.

---
 rtl/cache_data_array_nway_if.sv | 47 ++++
 rtl/cache_data_array_nway.sv | 186 ++++++++++++++++++
 tb/tb_cache_data_array_nway.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cache_data_array_nway_if.sv
// Bus bundle for the N-way cache data array: read port, byte-enabled
// write port and the block-fill port with its status outputs.
interface cache_data_array_nway_if #(
   parameter int WAY_W = 1,
   parameter int SET_W = 6,
   parameter int WRD_W = 3,
   parameter int DW    = 16
);
   localparam int BE_W = DW / 8;

   logic             rd_en;
   logic [WAY_W-1:0] rd_way;
   logic [SET_W-1:0] rd_set;
   logic [WRD_W-1:0] rd_word;
   logic [DW-1:0]    rd_data;
   logic             rd_valid;

   logic             wr_en;
   logic [WAY_W-1:0] wr_way;
   logic [SET_W-1:0] wr_set;
   logic [WRD_W-1:0] wr_word;
   logic [DW-1:0]    wr_data;
   logic [BE_W-1:0]  wr_be;
   logic             wr_drop;

   logic             fill_start;
   logic [WAY_W-1:0] fill_way;
   logic [SET_W-1:0] fill_set;
   logic             fill_valid;
   logic [DW-1:0]    fill_data;
   logic             fill_busy;
   logic             fill_done;

   modport master (
      output rd_en, rd_way, rd_set, rd_word,
      output wr_en, wr_way, wr_set, wr_word, wr_data, wr_be,
      output fill_start, fill_way, fill_set, fill_valid, fill_data,
      input  rd_data, rd_valid, wr_drop, fill_busy, fill_done
   );

   modport slave (
      input  rd_en, rd_way, rd_set, rd_word,
      input  wr_en, wr_way, wr_set, wr_word, wr_data, wr_be,
      input  fill_start, fill_way, fill_set, fill_valid, fill_data,
      output rd_data, rd_valid, wr_drop, fill_busy, fill_done
   );
endinterface

// File: rtl/cache_data_array_nway.sv
// N-way set-associative cache data store. Registered single-cycle read
// with write-first forwarding, byte-enabled single-word writes, and a
// block-fill sequencer that loads one word per accepted beat.
module cache_data_array_nway #(
   parameter int WAYS  = 2,
   parameter int SETS  = 64,
   parameter int WORDS = 8,
   parameter int DW    = 16
) (
   input logic                  clk,
   input logic                  rst,
   cache_data_array_nway_if.slave bus
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int SET_W = $clog2(SETS);
   localparam int WRD_W = $clog2(WORDS);
   localparam int BE_W  = DW / 8;
   // With a single way the way index carries no information and is dropped
   localparam int AW    = (WAYS > 1) ? (WAY_W + SET_W + WRD_W) : (SET_W + WRD_W);
   localparam int DEPTH = WAYS * SETS * WORDS;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

   // Flat storage index: way is the most significant field
   function automatic logic [AW-1:0] f_idx(input logic [WAY_W-1:0] way,
                                           input logic [SET_W-1:0] set,
                                           input logic [WRD_W-1:0] word);
      logic [WAY_W+SET_W+WRD_W-1:0] v_cat;
      v_cat = {way, set, word};
      return v_cat[AW-1:0];
   endfunction

   // Replace only the bytes whose enable bit is set
   function automatic logic [DW-1:0] f_be_merge(input logic [DW-1:0]   old_word,
                                                input logic [DW-1:0]   new_word,
                                                input logic [BE_W-1:0] be);
      logic [DW-1:0] v_res;
      v_res = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) begin
            v_res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            v_res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return v_res;
   endfunction

   logic [DW-1:0]    r_mem [DEPTH];
   state_t           r_state;
   state_t           w_state_nxt;
   logic [WRD_W-1:0] r_cnt;
   logic [WAY_W-1:0] r_fill_way;
   logic [SET_W-1:0] r_fill_set;
   logic [DW-1:0]    r_rd_data;
   logic             r_rd_valid;
   logic             r_wr_drop;
   logic             r_fill_done;

   logic             w_cnt_last;
   logic             w_fill_accept;
   logic             w_fill_we;
   logic             w_fill_last;
   logic             w_wr_we;
   logic             w_wr_drop;
   logic [AW-1:0]    w_rd_idx;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_fill_idx;
   logic [DW-1:0]    w_rd_word;

   assign w_cnt_last = (r_cnt == WRD_W'(WORDS - 1));
   assign w_rd_idx   = f_idx(bus.rd_way, bus.rd_set, bus.rd_word);
   assign w_wr_idx   = f_idx(bus.wr_way, bus.wr_set, bus.wr_word);
   assign w_fill_idx = f_idx(r_fill_way, r_fill_set, r_cnt);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: IDLE -> FILL on fill_start, back after the last beat
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.fill_start) w_state_nxt = ST_FILL;
            else                w_state_nxt = ST_IDLE;
         end
         ST_FILL: begin
            if (bus.fill_valid && w_cnt_last) w_state_nxt = ST_IDLE;
            else                              w_state_nxt = ST_FILL;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: which write source owns the array this cycle
   always_comb begin
      w_fill_accept = 1'b0;
      w_fill_we     = 1'b0;
      w_fill_last   = 1'b0;
      w_wr_we       = 1'b0;
      w_wr_drop     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_fill_accept = bus.fill_start;
            w_wr_we       = bus.wr_en;
         end
         ST_FILL: begin
            w_fill_we   = bus.fill_valid;
            w_fill_last = bus.fill_valid & w_cnt_last;
            w_wr_drop   = bus.wr_en;
         end
         default: begin
            w_fill_accept = 1'b0;
         end
      endcase
   end

   // Fill sequencer: latch target line on start, advance counter per beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= {WRD_W{1'b0}};
         r_fill_way <= {WAY_W{1'b0}};
         r_fill_set <= {SET_W{1'b0}};
      end else if (w_fill_accept) begin
         r_cnt      <= {WRD_W{1'b0}};
         r_fill_way <= bus.fill_way;
         r_fill_set <= bus.fill_set;
      end else if (w_fill_we) begin
         r_cnt      <= r_cnt + WRD_W'(1);
      end
   end

   // Storage update: fill beats are full-word, single writes are byte-merged
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DW{1'b0}};
         end
      end else if (w_fill_we) begin
         r_mem[w_fill_idx] <= bus.fill_data;
      end else if (w_wr_we) begin
         r_mem[w_wr_idx] <= f_be_merge(r_mem[w_wr_idx], bus.wr_data, bus.wr_be);
      end
   end

   // Write-first read value: forward a same-cycle write to the read address
   always_comb begin
      w_rd_word = r_mem[w_rd_idx];
      if (w_fill_we && (w_fill_idx == w_rd_idx)) begin
         w_rd_word = bus.fill_data;
      end else if (w_wr_we && (w_wr_idx == w_rd_idx)) begin
         w_rd_word = f_be_merge(r_mem[w_rd_idx], bus.wr_data, bus.wr_be);
      end else begin
         w_rd_word = r_mem[w_rd_idx];
      end
   end

   // Registered outputs: read data/valid and single-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data   <= {DW{1'b0}};
         r_rd_valid  <= 1'b0;
         r_wr_drop   <= 1'b0;
         r_fill_done <= 1'b0;
      end else begin
         if (bus.rd_en) begin
            r_rd_data <= w_rd_word;
         end
         r_rd_valid  <= bus.rd_en;
         r_wr_drop   <= w_wr_drop;
         r_fill_done <= w_fill_last;
      end
   end

   assign bus.rd_data   = r_rd_data;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.wr_drop   = r_wr_drop;
   assign bus.fill_done = r_fill_done;
   assign bus.fill_busy = (r_state == ST_FILL);
endmodule

// File: tb/tb_cache_data_array_nway.sv
// Scoreboard bench for cache_data_array_nway: stimulus pushes expected
// read data and pulse counts, a negedge monitor pops and compares.
module tb_cache_data_array_nway;
   logic clk;
   logic rst;

   cache_data_array_nway_if #(.WAY_W(1), .SET_W(6), .WRD_W(3), .DW(16)) bus ();

   cache_data_array_nway #(.WAYS(2), .SETS(64), .WORDS(8), .DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] q_rd [$];
   int          exp_drop = 0;
   int          exp_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: compare every presented output against the scoreboard
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         chk("rd_valid_expected", 32'(q_rd.size() > 0), 32'd1);
         if (q_rd.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(q_rd.pop_front()));
      end
      if (bus.wr_drop === 1'b1) begin
         chk("wr_drop_expected", 32'(exp_drop > 0), 32'd1);
         if (exp_drop > 0) exp_drop--;
      end
      if (bus.fill_done === 1'b1) begin
         chk("fill_done_expected", 32'(exp_done > 0), 32'd1);
         if (exp_done > 0) exp_done--;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.rd_en = 1'b0;      bus.rd_way = 1'b0;     bus.rd_set = 6'd0;   bus.rd_word = 3'd0;
      bus.wr_en = 1'b0;      bus.wr_way = 1'b0;     bus.wr_set = 6'd0;   bus.wr_word = 3'd0;
      bus.wr_data = 16'h0;   bus.wr_be = 2'b00;
      bus.fill_start = 1'b0; bus.fill_way = 1'b0;   bus.fill_set = 6'd0;
      bus.fill_valid = 1'b0; bus.fill_data = 16'h0;
   endtask

   task automatic set_rd(input logic w, input logic [5:0] s, input logic [2:0] wd, input logic [15:0] e);
      bus.rd_en = 1'b1; bus.rd_way = w; bus.rd_set = s; bus.rd_word = wd;
      q_rd.push_back(e);
   endtask

   task automatic set_wr(input logic w, input logic [5:0] s, input logic [2:0] wd,
                         input logic [15:0] d, input logic [1:0] be);
      bus.wr_en = 1'b1; bus.wr_way = w; bus.wr_set = s; bus.wr_word = wd;
      bus.wr_data = d; bus.wr_be = be;
   endtask

   task automatic do_read(input logic w, input logic [5:0] s, input logic [2:0] wd, input logic [15:0] e);
      set_rd(w, s, wd, e);
      tick();
      clear_inputs();
   endtask

   task automatic do_write(input logic w, input logic [5:0] s, input logic [2:0] wd,
                           input logic [15:0] d, input logic [1:0] be);
      set_wr(w, s, wd, d, be);
      tick();
      clear_inputs();
   endtask

   task automatic start_fill(input logic w, input logic [5:0] s);
      bus.fill_start = 1'b1; bus.fill_way = w; bus.fill_set = s;
      tick();
      clear_inputs();
      chk("fill_busy_after_start", 32'(bus.fill_busy), 32'd1);
   endtask

   task automatic beat(input logic [15:0] d, input logic last);
      bus.fill_valid = 1'b1; bus.fill_data = d;
      if (last) exp_done++;
      tick();
      clear_inputs();
      chk("fill_busy_beat", 32'(bus.fill_busy), last ? 32'd0 : 32'd1);
      if (last) chk("fill_done_pulse", 32'(bus.fill_done), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick(); tick();
      chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
      chk("rst_rd_data",   32'(bus.rd_data),   32'd0);
      chk("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
      chk("rst_fill_done", 32'(bus.fill_done), 32'd0);
      chk("rst_wr_drop",   32'(bus.wr_drop),   32'd0);
      rst = 1'b0;
      tick();

      // Reset contents and byte-enabled writes
      do_read(1'b1, 6'd63, 3'd7, 16'h0000);
      do_write(1'b0, 6'd5, 3'd3, 16'hBEEF, 2'b11);
      do_write(1'b0, 6'd5, 3'd3, 16'h1234, 2'b10);
      do_write(1'b0, 6'd5, 3'd3, 16'hFFFF, 2'b00);
      do_read(1'b0, 6'd5, 3'd3, 16'h12EF);
      do_read(1'b1, 6'd5, 3'd3, 16'h0000);
      // Same-cycle write and read: low byte only, forwarded
      set_wr(1'b0, 6'd6, 3'd1, 16'hCAFE, 2'b01);
      set_rd(1'b0, 6'd6, 3'd1, 16'h00FE);
      tick();
      clear_inputs();
      do_read(1'b0, 6'd6, 3'd1, 16'h00FE);

      // Fill w1/s10; fill_valid alongside fill_start must be ignored
      bus.fill_valid = 1'b1; bus.fill_data = 16'hDEAD;
      start_fill(1'b1, 6'd10);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            set_wr(1'b0, 6'd0, 3'd0, 16'hAAAA, 2'b11);
            exp_drop++;
            tick();
            clear_inputs();
            chk("fill_busy_stall1", 32'(bus.fill_busy), 32'd1);
            bus.fill_start = 1'b1; bus.fill_way = 1'b0; bus.fill_set = 6'd1;
            tick();
            clear_inputs();
            chk("fill_busy_stall2", 32'(bus.fill_busy), 32'd1);
         end
         if (i == 2) set_rd(1'b1, 6'd10, 3'd2, 16'h1002);
         beat(16'h1000 + 16'(i), i == 7);
      end
      // fill_start while fill_done is high is accepted
      start_fill(1'b1, 6'd11);
      for (int i = 0; i < 8; i++) beat(16'h2000 + 16'(i), i == 7);
      tick();
      for (int i = 0; i < 8; i++) do_read(1'b1, 6'd10, 3'(i), 16'h1000 + 16'(i));
      for (int i = 0; i < 8; i++) do_read(1'b1, 6'd11, 3'(i), 16'h2000 + 16'(i));
      do_read(1'b0, 6'd0, 3'd0, 16'h0000);
      do_read(1'b0, 6'd1, 3'd0, 16'h0000);
      do_read(1'b0, 6'd1, 3'd4, 16'h0000);

      // Reset after beat 4 aborts the fill and clears storage
      start_fill(1'b0, 6'd20);
      for (int i = 0; i < 5; i++) beat(16'h3000 + 16'(i), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_fill_busy", 32'(bus.fill_busy), 32'd0);
      chk("rst_mid_fill_done", 32'(bus.fill_done), 32'd0);
      tick(); tick();
      for (int i = 0; i < 5; i++) do_read(1'b0, 6'd20, 3'(i), 16'h0000);
      do_read(1'b0, 6'd5,  3'd3, 16'h0000);
      do_read(1'b1, 6'd10, 3'd0, 16'h0000);
      do_read(1'b1, 6'd11, 3'd7, 16'h0000);

      // New fill with a same-cycle read of the beat being written
      start_fill(1'b1, 6'd10);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            set_rd(1'b1, 6'd10, 3'd2, 16'h5555);
            beat(16'h5555, 1'b0);
         end else begin
            beat(16'h4000 + 16'(i), i == 7);
         end
      end
      for (int i = 0; i < 8; i++)
         do_read(1'b1, 6'd10, 3'(i), (i == 2) ? 16'h5555 : 16'h4000 + 16'(i));

      tick(); tick(); tick();
      chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
      chk("wr_drop_pending",  32'(exp_drop),    32'd0);
      chk("fill_done_pending", 32'(exp_done),   32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
